// File: rtl/mo_pkg.sv
// Shared constants and elaboration helpers for the mo_arb output mixer.
package mo_pkg;

   localparam int unsigned MO_MODE_FIXED = 0;
   localparam int unsigned MO_MODE_RR    = 1;

   // Ceiling log2; valid for the small constant widths used at elaboration.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/mo_arb_pick.sv
// Find-first-set over an N-bit mask starting at start_i. wrap_i=1 searches upward with
// wrap modulo N (round-robin); wrap_i=0 searches downward from start_i to 0 (fixed priority).
module mo_arb_pick import mo_pkg::*; #(
   parameter int unsigned N = 5,
   localparam int unsigned IW = clog2(N)
) (
   input  logic [N-1:0]  mask_i,
   input  logic [IW-1:0] start_i,
   input  logic          wrap_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   always_comb begin
      int            best_d;
      int            d;
      logic [IW-1:0] best;
      best_d = int'(N);
      best   = '0;
      d      = 0;
      // Each set bit is scored by its search distance from start_i; the closest wins.
      for (int k = 0; k < int'(N); k++) begin
         if (wrap_i) begin
            d = k - int'(start_i);
            if (d < 0) begin
               d = d + int'(N);
            end
         end else begin
            d = int'(start_i) - k;
            if (d < 0) begin
               d = int'(N);
            end
         end
         if (mask_i[k] && (d < best_d)) begin
            best_d = d;
            best   = IW'(k);
         end
      end
      found_o  = (best_d < int'(N));
      idx_o    = best;
      onehot_o = '0;
      for (int k = 0; k < int'(N); k++) begin
         onehot_o[k] = found_o && (best == IW'(k));
      end
   end

endmodule

// File: rtl/mo_arb.sv
// N-channel arbitrating output mixer: registered one-hot grant with fixed-priority or
// round-robin selection, a burst-hold limit, and a combinational data mux on the grant.
module mo_arb import mo_pkg::*; #(
   parameter int unsigned N        = 5,
   parameter int unsigned DW       = 32,
   parameter int unsigned MODE     = 1,
   parameter int unsigned MAX_HOLD = 16,
   localparam int unsigned IW      = clog2(N)
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [N-1:0]  req,
   input  logic [N*DW-1:0] din,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic [DW-1:0] dout,
   output logic          dout_vld
);

   localparam int unsigned HW          = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
   localparam int unsigned HoldLastInt = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [HW-1:0] HoldLast  = HW'(HoldLastInt);
   localparam logic [IW-1:0] LastIdx   = IW'(N - 1);
   localparam logic          RrMode    = (MODE == MO_MODE_RR);

   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic          vld_q, vld_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hcnt_q, hcnt_d;

   logic          holder_req;
   logic          others;
   logic          at_limit;
   logic          hcnt_sat;
   logic          keep;
   logic [N-1:0]  elig;
   logic [IW-1:0] start;
   logic [N-1:0]  pick_onehot;
   logic [IW-1:0] pick_idx;
   logic          pick_found;

   always_comb begin
      holder_req = |(req & gnt_q);
      others     = |(req & ~gnt_q);
      at_limit   = (MAX_HOLD != 0) && (hcnt_q == HoldLast);
      hcnt_sat   = (MAX_HOLD == 0) ? (hcnt_q == '1) : at_limit;
      keep       = holder_req && (!at_limit || !others);
      // A holder that is still requesting but out of budget yields to the others.
      elig       = holder_req ? (req & ~gnt_q) : req;
      if (RrMode) begin
         start = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;
      end else begin
         start = LastIdx;
      end
   end

   mo_arb_pick #(
      .N (N)
   ) u_pick (
      .mask_i   (elig),
      .start_i  (start),
      .wrap_i   (RrMode),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .found_o  (pick_found)
   );

   always_comb begin
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      vld_d    = vld_q;
      ptr_d    = ptr_q;
      hcnt_d   = hcnt_q;
      if (keep) begin
         if (!hcnt_sat) begin
            hcnt_d = hcnt_q + 1'b1;
         end
      end else if (pick_found) begin
         gnt_d    = pick_onehot;
         gnt_id_d = pick_idx;
         vld_d    = 1'b1;
         ptr_d    = pick_idx;
         hcnt_d   = '0;
      end else begin
         gnt_d    = '0;
         gnt_id_d = '0;
         vld_d    = 1'b0;
         hcnt_d   = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         gnt_q    <= '0;
         gnt_id_q <= '0;
         vld_q    <= 1'b0;
         ptr_q    <= LastIdx;
         hcnt_q   <= '0;
      end else begin
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         vld_q    <= vld_d;
         ptr_q    <= ptr_d;
         hcnt_q   <= hcnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign gnt_id   = gnt_id_q;
   assign dout_vld = vld_q;
   assign dout     = din[int'(gnt_id_q) * DW +: DW];

endmodule
